// File: rtl/alu_nibble_seq.sv
// Sequencer that runs a word-wide operation through one external combinational
// 4-bit ALU slice, one nibble per cycle, chaining carries between nibbles.
module alu_nibble_seq #(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [2:0]   op_f,
  input  logic         op_com,
  input  logic         op_cin,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [2:0]   alu_f,
  output logic         alu_com,
  output logic         alu_ci_right,
  output logic         alu_ci_left,
  input  logic [3:0]   alu_d,
  input  logic         alu_co_left,
  input  logic         alu_co_right,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SHR = 3'd6;
  localparam logic [2:0] F_SHL = 3'd7;

  localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [W-1:0]  a_q, b_q;
  logic [2:0]    f_q;
  logic          com_q, cin_q, chain_q;

  logic          running, is_shr, chains_left, first;
  logic [KW-1:0] idx;
  logic          chain_in, chain_new;
  logic [W-1:0]  result_next;

  assign running     = (state == RUN);
  assign is_shr      = (f_q == F_SHR);
  assign chains_left = (f_q == F_ADD) || (f_q == F_SHL);
  assign first       = (k == '0);
  // SHR walks from the most significant nibble so the shift-in travels downward.
  assign idx         = is_shr ? (LAST - k) : k;
  assign chain_in    = first ? cin_q : chain_q;
  assign chain_new   = is_shr ? alu_co_right : alu_co_left;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign alu_a        = running ? a_q[idx*4 +: 4] : 4'h0;
  assign alu_b        = running ? b_q[idx*4 +: 4] : 4'h0;
  assign alu_f        = running ? f_q : 3'd0;
  assign alu_com      = running ? com_q : 1'b0;
  assign alu_ci_right = running && chains_left ? chain_in : 1'b0;
  assign alu_ci_left  = running && is_shr ? chain_in : 1'b0;

  // NOTE: default assignment first, then override, so no latch is inferred.
  always_comb begin
    result_next = result;
    result_next[idx*4 +: 4] = alu_d;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      f_q       <= '0;
      com_q     <= 1'b0;
      cin_q     <= 1'b0;
      chain_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= op_b;
            f_q     <= op_f;
            com_q   <= op_com;
            cin_q   <= op_cin;
            chain_q <= 1'b0;
            k       <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          result  <= result_next;
          chain_q <= chain_new;
          if (k == LAST) begin
            carry_out <= (chains_left || is_shr) ? chain_new : 1'b0;
            zero      <= (result_next == '0);
            k         <= '0;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_nibble_seq.md
ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

Purpose: upstream controller that drives one external 4-bit ALU slice over NIBBLES cycles to run a word-wide operation, chaining carries and collecting the result.

Interface
REQ-001 Parameter NIBBLES, default 4: nibbles per word; word width W = 4*NIBBLES.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op_a  input  W  operand A.
REQ-007 op_b  input  W  operand B.
REQ-008 op_f  input  3  ALU function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
REQ-009 op_com  input  1  ones-complement output mode.
REQ-010 op_cin  input  1  carry/shift-in for the word (ADD carry-in, SHL LSB fill, SHR MSB fill).
REQ-011 alu_a, alu_b  output  4 each  nibble operands to slice.
REQ-012 alu_f  output  3  function code to slice; alu_com  output  1  COM to slice.
REQ-013 alu_ci_right, alu_ci_left  output  1 each  carry inputs to slice.
REQ-014 alu_d  input  4  slice result; alu_co_left, alu_co_right  input  1 each  slice carry outputs.
REQ-015 out_valid  output  1  result valid; out_ready  input  1  consumer accepts result.
REQ-016 result  output  W  word result; carry_out  output  1  final carry/shift-out; zero  output  1  result == 0.

Function
REQ-017 States: IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 IDLE: in_valid=1 -> latch op_a, op_b, op_f, op_com, op_cin; nibble index k=0; go to RUN next cycle.
REQ-019 RUN lasts exactly NIBBLES cycles; one nibble per cycle; slice is purely combinational, alu_d/carries sampled same cycle.
REQ-020 Order: SHR processes nibbles MSB first (index NIBBLES-1 down to 0); all other functions LSB first (index 0 up).
REQ-021 alu_a/alu_b = current nibble of latched A/B; alu_f, alu_com = latched values, held constant through RUN.
REQ-022 ADD/SHL: alu_ci_right = op_cin on first nibble, else registered alu_co_left of previous nibble; alu_ci_left = 0.
REQ-023 SHR: alu_ci_left = op_cin on first nibble, else registered alu_co_right of previous nibble; alu_ci_right = 0.
REQ-024 Functions 1-5: both ci = 0; carry_out = 0.
REQ-025 alu_d written into result nibble of current index each RUN cycle; other nibbles unchanged.
REQ-026 carry_out = last-nibble alu_co_left (ADD/SHL) or alu_co_right (SHR), registered on final RUN cycle.
REQ-027 After final RUN cycle go to DONE; zero = (result == 0) computed on completed word, including COM effect.
REQ-028 DONE: result, carry_out, zero, out_valid held stable until out_ready=1; then IDLE next cycle.
REQ-029 Latency: accept edge to out_valid = NIBBLES+1 cycles; throughput one op per NIBBLES+2 cycles minimum.
REQ-030 in_valid ignored outside IDLE; no request queued.
REQ-031 Outside RUN: alu_a, alu_b, alu_f, alu_com, alu_ci_* driven 0.

Reset
REQ-032 rst=1 at any clock edge, any state (including mid-RUN): state IDLE, k=0, result=0, carry_out=0, zero=0, out_valid=0, in_ready=1 following cycle, all alu_* outputs 0; partial operation discarded.
REQ-033 rst has priority over in_valid and out_ready in the same cycle.

Verification (bench includes behavioural 4-bit ALU slice model; NIBBLES=4)
REQ-034 ADD A=0xFFFF B=0x0001 cin=0 -> out_valid 5 cycles after accept; result=0x0000, carry_out=1, zero=1.
REQ-035 SHL A=0x8001 cin=1 -> result=0x0003, carry_out=1; SHR A=0x8001 cin=0 -> result=0x4000, carry_out=1; SHR alu_a sequence 0x8,0x0,0x0,0x1.
REQ-036 XOR A=0x1234 B=0x1234 com=1 -> result=0xFFFF, zero=0, carry_out=0; com=0 -> result=0x0000, zero=1.
REQ-037 Backpressure: out_ready=0 for 10 cycles after DONE -> outputs stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-038 rst asserted in 2nd RUN cycle of ADD 0x1111+0x2222 -> next cycle IDLE, result=0, out_valid=0; new ADD 0x0005+0x0003 -> 0x0008.
